// File: rtl/fifo_rst_pkg.sv
// Shared types and defaults for the FIFO reset sequencing controller.
// Holds the sequencer state set, the default timing parameters and the counter width helper.
package fifo_rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_REL_WR,
        ST_REL_RD,
        ST_REL_FLAG,
        ST_READY,
        ST_DRAIN,
        ST_ASSERT
    } state_t;

    localparam int DEF_STAGE_DLY = 4;
    localparam int DEF_FLUSH_TMO = 64;

    // The counter must be able to hold FLUSH_TMO itself, not just FLUSH_TMO-1.
    function automatic int cnt_width(input int stage_dly, input int flush_tmo);
        int max_val;
        max_val = (stage_dly > flush_tmo) ? stage_dly : flush_tmo;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchronizer: assertion passes through asynchronously,
// deassertion is retimed to i_clk.
module rst_sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    localparam int STAGES = 2;

    logic [STAGES:0] chain_reg;

    assign chain_reg[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    chain_reg[gi+1] <= 1'b0;
                end else begin
                    chain_reg[gi+1] <= chain_reg[gi];
                end
            end
        end
    endgenerate

    assign o_rst_n = chain_reg[STAGES];

endmodule

// File: rtl/fifo_rst_ctrl.sv
// FIFO reset sequencer: releases write, read and flag resets in a staggered order
// after board reset, and re-runs that sequence on a software flush request.
module fifo_rst_ctrl
    import fifo_rst_pkg::*;
#(
    parameter int STAGE_DLY = DEF_STAGE_DLY,
    parameter int FLUSH_TMO = DEF_FLUSH_TMO
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_flush_req,
    input  logic i_fifo_idle,
    output logic o_wr_rst_n,
    output logic o_rd_rst_n,
    output logic o_flag_rst_n,
    output logic o_ready,
    output logic o_flush_ack,
    output logic o_tmo
);

    localparam int CNT_W = cnt_width(STAGE_DLY, FLUSH_TMO);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(FLUSH_TMO);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic             rst_sync_n;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             arm_reg, arm_next;
    logic             pend_reg, pend_next;
    logic             tmo_reg, tmo_next;
    logic             wr_reg, rd_reg, flag_reg, ready_reg, ack_reg;
    logic             ack_next;
    logic             accept;
    logic             timeout;
    logic             stage_done;

    rst_sync_2ff u_rst_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_rst_n (rst_sync_n)
    );

    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
            arm_reg   <= 1'b1;
            pend_reg  <= 1'b0;
            tmo_reg   <= 1'b0;
            wr_reg    <= 1'b0;
            rd_reg    <= 1'b0;
            flag_reg  <= 1'b0;
            ready_reg <= 1'b0;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            arm_reg   <= arm_next;
            pend_reg  <= pend_next;
            tmo_reg   <= tmo_next;
            wr_reg    <= state_next inside {ST_REL_RD, ST_REL_FLAG, ST_READY, ST_DRAIN};
            rd_reg    <= state_next inside {ST_REL_FLAG, ST_READY, ST_DRAIN};
            flag_reg  <= state_next inside {ST_READY, ST_DRAIN};
            ready_reg <= (state_next == ST_READY);
            ack_reg   <= ack_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        timeout    = 1'b0;
        stage_done = (cnt_reg == STAGE_LAST);
        case (state_reg)
            ST_HOLD:     state_next = ST_REL_WR;
            ST_REL_WR:   if (stage_done) state_next = ST_REL_RD;
            ST_REL_RD:   if (stage_done) state_next = ST_REL_FLAG;
            ST_REL_FLAG: if (stage_done) state_next = ST_READY;
            ST_READY: begin
                if (i_flush_req && arm_reg) begin
                    accept     = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            // Idle is checked first so a coincident timeout does not flag o_tmo.
            ST_DRAIN: begin
                if (i_fifo_idle) begin
                    state_next = ST_ASSERT;
                end else if (cnt_reg == TMO_LAST) begin
                    timeout    = 1'b1;
                    state_next = ST_ASSERT;
                end
            end
            ST_ASSERT:   if (stage_done) state_next = ST_REL_WR;
            default:     state_next = ST_HOLD;
        endcase
    end

    always_comb begin
        arm_next  = arm_reg;
        pend_next = pend_reg;
        tmo_next  = tmo_reg;
        ack_next  = (state_next == ST_READY) && (state_reg != ST_READY) && pend_reg;
        if (accept) begin
            arm_next  = 1'b0;
            pend_next = 1'b1;
            tmo_next  = 1'b0;
        end else if (!i_flush_req) begin
            arm_next  = 1'b1;
        end
        if (timeout) begin
            tmo_next = 1'b1;
        end
        if (ack_next) begin
            pend_next = 1'b0;
        end
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = cnt_reg;
        end
    end

    assign o_wr_rst_n   = wr_reg;
    assign o_rd_rst_n   = rd_reg;
    assign o_flag_rst_n = flag_reg;
    assign o_ready      = ready_reg;
    assign o_flush_ack  = ack_reg;
    assign o_tmo        = tmo_reg;

endmodule

// File: tb/tb_fifo_rst_ctrl.sv
// Bench for fifo_rst_ctrl: directed timing scenarios plus random flush/idle/reset traffic,
// checked every cycle against an event-schedule model of the release timeline.
module tb_fifo_rst_ctrl;

    localparam int S = 4;
    localparam int T = 64;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_flush_req;
    logic i_fifo_idle;
    logic o_wr_rst_n, o_rd_rst_n, o_flag_rst_n, o_ready, o_flush_ack, o_tmo;
    logic [5:0] dut_vec;

    fifo_rst_ctrl #(.STAGE_DLY(S), .FLUSH_TMO(T)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush_req  (i_flush_req),
        .i_fifo_idle  (i_fifo_idle),
        .o_wr_rst_n   (o_wr_rst_n),
        .o_rd_rst_n   (o_rd_rst_n),
        .o_flag_rst_n (o_flag_rst_n),
        .o_ready      (o_ready),
        .o_flush_ack  (o_flush_ack),
        .o_tmo        (o_tmo)
    );

    always #5 i_clk = ~i_clk;

    assign dut_vec = {o_wr_rst_n, o_rd_rst_n, o_flag_rst_n, o_ready, o_flush_ack, o_tmo};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int e0 = 0;
    int k = 0;
    int ack_base = 0;

    // Model: outputs plus the edge numbers at which scheduled releases happen.
    bit m_wr, m_rd, m_flag, m_ready, m_ack, m_tmo;
    bit m_arm, m_in_rst, m_pend, m_drain;
    int m_dstart, t_wr, t_rd, t_flag;

    // Edge timestamps observed on the DUT outputs.
    int r_wr = -1, r_rd = -1, r_flag = -1, r_ready = -1, r_ack = -1;
    int f_wr = -1, f_ready = -1, ack_cnt = 0;
    logic [5:0] p_vec = '0;

    int  req_left = 0;
    bit  req_v = 1'b0;
    bit  idle_v = 1'b1;
    int  mode = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] model_vec();
        return {m_wr, m_rd, m_flag, m_ready, m_ack, m_tmo};
    endfunction

    task automatic model_reset();
        {m_wr, m_rd, m_flag, m_ready, m_ack, m_tmo} = '0;
        m_arm    = 1'b1;
        m_in_rst = 1'b1;
        m_pend   = 1'b0;
        m_drain  = 1'b0;
        t_wr     = -1;
        t_rd     = -1;
        t_flag   = -1;
    endtask

    task automatic model_release();
        m_in_rst = 1'b0;
        e0       = cyc + 1;
        t_wr     = e0 + 2 + S;
        t_rd     = e0 + 2 + 2 * S;
        t_flag   = e0 + 2 + 3 * S;
    endtask

    task automatic model_fall(input int a);
        m_wr    = 1'b0;
        m_rd    = 1'b0;
        m_flag  = 1'b0;
        m_drain = 1'b0;
        t_wr    = a + 2 * S;
        t_rd    = a + 3 * S;
        t_flag  = a + 4 * S;
    endtask

    task automatic model_edge(input bit req, input bit idle);
        bit was_ready;
        if (m_in_rst) return;
        was_ready = m_ready;
        m_ack = 1'b0;
        if (m_drain) begin
            if (idle) begin
                model_fall(cyc);
            end else if (cyc - m_dstart == T + 1) begin
                model_fall(cyc);
                m_tmo = 1'b1;
            end
        end
        if (cyc == t_wr) m_wr = 1'b1;
        if (cyc == t_rd) m_rd = 1'b1;
        if (cyc == t_flag) begin
            m_flag  = 1'b1;
            m_ready = 1'b1;
            if (m_pend) begin
                m_ack  = 1'b1;
                m_pend = 1'b0;
            end
        end
        if (was_ready && req && m_arm) begin
            m_ready  = 1'b0;
            m_tmo    = 1'b0;
            m_arm    = 1'b0;
            m_drain  = 1'b1;
            m_dstart = cyc;
            m_pend   = 1'b1;
            $display("flush accepted at cycle %0d idle=%0b", cyc, idle);
        end else if (!req) begin
            m_arm = 1'b1;
        end
    endtask

    task automatic step(input bit req, input bit idle);
        i_flush_req = req;
        i_fifo_idle = idle;
        @(posedge i_clk);
        cyc++;
        model_edge(req, idle);
        @(negedge i_clk);
        check_eq("outs", {26'd0, dut_vec}, {26'd0, model_vec()});
    endtask

    task automatic pulse_reset(input int low_cycles);
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_async", {26'd0, dut_vec}, {26'd0, model_vec()});
        repeat (low_cycles) step(1'b0, 1'b1);
        i_rst_n = 1'b1;
        model_release();
    endtask

    always @(posedge i_clk) begin
        #1;
        if (dut_vec[5] && !p_vec[5]) r_wr = cyc;
        if (!dut_vec[5] && p_vec[5]) f_wr = cyc;
        if (dut_vec[4] && !p_vec[4]) r_rd = cyc;
        if (dut_vec[3] && !p_vec[3]) r_flag = cyc;
        if (dut_vec[2] && !p_vec[2]) r_ready = cyc;
        if (!dut_vec[2] && p_vec[2]) f_ready = cyc;
        if (dut_vec[1] && !p_vec[1]) r_ack = cyc;
        if (o_flush_ack) ack_cnt++;
        p_vec = dut_vec;
    end

    initial begin
        i_rst_n     = 1'b0;
        i_flush_req = 1'b0;
        i_fifo_idle = 1'b1;
        model_reset();
        @(negedge i_clk);
        check_eq("reset_state", {26'd0, dut_vec}, 32'd0);
        repeat (3) step(1'b0, 1'b1);

        // Power-up release timeline.
        i_rst_n = 1'b1;
        model_release();
        ack_base = ack_cnt;
        while (cyc < e0 + 16) step(1'b0, 1'b1);
        check_eq("pu_wr_edge", r_wr - e0, 2 + S);
        check_eq("pu_rd_edge", r_rd - e0, 2 + 2 * S);
        check_eq("pu_flag_edge", r_flag - e0, 2 + 3 * S);
        check_eq("pu_ready_edge", r_ready - e0, 2 + 3 * S);
        check_eq("pu_no_ack", ack_cnt - ack_base, 0);

        // Flush accepted at edge 20 with the FIFO idle.
        while (cyc + 1 < e0 + 20) step(1'b0, 1'b1);
        k = cyc + 1;
        ack_base = ack_cnt;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        while (cyc < k + 1 + 4 * S + 3) step(1'b0, 1'b1);
        check_eq("fl_ready_fall", f_ready - e0, 20);
        check_eq("fl_wr_fall", f_wr - e0, 21);
        check_eq("fl_wr_edge", r_wr - e0, 29);
        check_eq("fl_rd_edge", r_rd - e0, 33);
        check_eq("fl_flag_edge", r_flag - e0, 37);
        check_eq("fl_ack_edge", r_ack - e0, 37);
        check_eq("fl_ack_width", ack_cnt - ack_base, 1);
        check_eq("fl_tmo", {31'd0, o_tmo}, 0);

        // Idle never arrives: forced by timeout, request held high throughout.
        k = cyc + 1;
        ack_base = ack_cnt;
        repeat (150) step(1'b1, 1'b0);
        check_eq("tmo_wr_fall", f_wr - k, 1 + T);
        check_eq("tmo_one_ack", ack_cnt - ack_base, 1);
        check_eq("tmo_sticky", {31'd0, o_tmo}, 1);
        step(1'b0, 1'b1);
        k = cyc + 1;
        step(1'b1, 1'b1);
        check_eq("tmo_cleared", {31'd0, o_tmo}, 0);
        while (cyc < k + 1 + 4 * S + 2) step(1'b0, 1'b1);

        // Idle rises in the same cycle the timeout expires.
        k = cyc + 1;
        ack_base = ack_cnt;
        step(1'b1, 1'b0);
        while (cyc + 1 < k + 1 + T) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        while (cyc < k + 1 + T + 4 * S + 2) step(1'b0, 1'b1);
        check_eq("tie_wr_fall", f_wr - k, 1 + T);
        check_eq("tie_tmo", {31'd0, o_tmo}, 0);
        check_eq("tie_ack", ack_cnt - ack_base, 1);

        // Board reset during ASSERT.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        pulse_reset(2);
        ack_base = ack_cnt;
        while (cyc < e0 + 16) step(1'b0, 1'b1);
        check_eq("rst_wr_edge", r_wr - e0, 2 + S);
        check_eq("rst_flag_edge", r_flag - e0, 2 + 3 * S);
        check_eq("rst_no_ack", ack_cnt - ack_base, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) mode = $urandom_range(0, 3);
            if (req_left == 0) begin
                req_v    = !req_v;
                req_left = req_v ? $urandom_range(1, 120) : $urandom_range(1, 20);
            end
            req_left--;
            case (mode)
                0:       idle_v = ($urandom_range(0, 3) != 0);
                1:       idle_v = ($urandom_range(0, 39) == 0);
                2:       idle_v = 1'b0;
                default: idle_v = 1'($urandom_range(0, 1));
            endcase
            step(req_v, idle_v);
            if ($urandom_range(0, 599) == 0) pulse_reset($urandom_range(1, 3));
        end
        repeat (100) step(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
